gmii_frame_gen: RTL and testbench

- Synthesizable, parametrised GMII transmit stimulus generator; successor to the fixed-sequence PCS TX tester.
- Drives TXD/TX_EN/TX_ER/xmit into the PCS transmit path.
- Emits a programmable number of frames (preamble, SFD, payload from a selectable pattern, inter-packet gap) with optional TX_ER injection.
- Sequences xmit from IDLE to DATA before the first frame.

---
 rtl/gmii_frame_gen_pkg.sv | 29 ++
 rtl/gmii_frame_gen_pattern_gen.sv | 33 +++
 rtl/gmii_frame_gen.sv | 178 +++++++++++++++++
 tb/tb_gmii_frame_gen.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/gmii_frame_gen_pkg.sv
// rtl/gmii_frame_gen_pkg.sv - shared GMII constants, pattern modes and FSM state encoding
package gmii_frame_gen_pkg;

   localparam logic [2:0] XMIT_IDLE     = 3'b001;
   localparam logic [2:0] XMIT_DATA     = 3'b010;
   localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0] SFD_BYTE      = 8'hD5;

   localparam logic [1:0] MODE_FIXED = 2'b00;
   localparam logic [1:0] MODE_INCR  = 2'b01;
   localparam logic [1:0] MODE_LFSR  = 2'b10;
   localparam logic [1:0] MODE_RSVD  = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_XWAIT = 3'd1,
      ST_PRE   = 3'd2,
      ST_SFD   = 3'd3,
      ST_PAY   = 3'd4,
      ST_IPG   = 3'd5,
      ST_FIN   = 3'd6
   } state_t;

   // Galois-free shift form: taps on bits 7,5,4,3 feed the new LSB
   function automatic logic [7:0] lfsr8_next(input logic [7:0] d);
      return {d[6:0], d[7] ^ d[5] ^ d[4] ^ d[3]};
   endfunction

endpackage

// File: rtl/gmii_frame_gen_pattern_gen.sv
// rtl/gmii_frame_gen_pattern_gen.sv - payload pattern register (fixed, incrementing, LFSR8)
module gmii_pattern_gen
   import gmii_frame_gen_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic       advance,
   input  logic [1:0] mode,
   input  logic [7:0] seed,
   output logic [7:0] data
);

   logic [7:0] pat;

   // Reload from seed (an all-zero LFSR would lock up, so it starts at 01), else step per mode
   always_ff @(posedge clk) begin
      if (rst) begin
         pat <= 8'h00;
      end else if (load) begin
         pat <= (mode == MODE_LFSR && seed == 8'h00) ? 8'h01 : seed;
      end else if (advance) begin
         case (mode)
            MODE_INCR: pat <= pat + 8'd1;
            MODE_LFSR: pat <= lfsr8_next(pat);
            default:   pat <= pat;
         endcase
      end
   end

   assign data = pat;

endmodule

// File: rtl/gmii_frame_gen.sv
// rtl/gmii_frame_gen.sv - GMII transmit stimulus generator: xmit sequencing, framed bursts, TX_ER injection
module gmii_frame_gen
   import gmii_frame_gen_pkg::*;
#(
   parameter int LEN_W        = 11,
   parameter int CNT_W        = 8,
   parameter int PREAMBLE_LEN = 7,
   parameter int IPG_LEN      = 12,
   parameter int XMIT_DELAY   = 5
) (
   input  logic             GTX_CLK,
   input  logic             mr_main_reset,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic [7:0]       seed,
   input  logic [LEN_W-1:0] payload_len,
   input  logic [CNT_W-1:0] frame_count,
   input  logic             err_en,
   input  logic [LEN_W-1:0] err_index,
   output logic [7:0]       TXD,
   output logic             TX_EN,
   output logic             TX_ER,
   output logic [2:0]       xmit,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] frames_sent
);

   localparam logic [LEN_W-1:0] XD_LAST  = LEN_W'(XMIT_DELAY - 1);
   localparam logic [LEN_W-1:0] PRE_LAST = LEN_W'(PREAMBLE_LEN - 1);
   localparam logic [LEN_W-1:0] IPG_LAST = LEN_W'(IPG_LEN - 1);

   state_t           state;
   logic [LEN_W-1:0] cnt;
   logic [1:0]       mode_q;
   logic [7:0]       seed_q;
   logic [LEN_W-1:0] len_q;
   logic [CNT_W-1:0] fc_q;
   logic             err_q;
   logic [LEN_W-1:0] eidx_q;
   logic [7:0]       pat_byte;
   logic             pat_load;
   logic             pat_adv;
   logic [CNT_W-1:0] sent_inc;

   // Pattern is re-seeded during every preamble and steps each time a payload byte is registered
   assign pat_load = (state == ST_PRE);
   assign pat_adv  = (state == ST_SFD && len_q != '0) ||
                     (state == ST_PAY && cnt != len_q - 1'b1);
   assign sent_inc = (frames_sent == '1) ? frames_sent : frames_sent + 1'b1;

   gmii_pattern_gen u_pattern (
      .clk     (GTX_CLK),
      .rst     (mr_main_reset),
      .load    (pat_load),
      .advance (pat_adv),
      .mode    (mode_q),
      .seed    (seed_q),
      .data    (pat_byte)
   );

   // Frame sequencer; every output is registered alongside the state it belongs to
   always_ff @(posedge GTX_CLK) begin
      if (mr_main_reset) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         TXD         <= 8'h00;
         TX_EN       <= 1'b0;
         TX_ER       <= 1'b0;
         xmit        <= XMIT_IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         frames_sent <= '0;
         mode_q      <= MODE_FIXED;
         seed_q      <= 8'h00;
         len_q       <= '0;
         fc_q        <= '0;
         err_q       <= 1'b0;
         eidx_q      <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  mode_q      <= mode;
                  seed_q      <= seed;
                  len_q       <= payload_len;
                  fc_q        <= frame_count;
                  err_q       <= err_en;
                  eidx_q      <= err_index;
                  frames_sent <= '0;
                  busy        <= 1'b1;
                  xmit        <= XMIT_DATA;
                  cnt         <= '0;
                  state       <= ST_XWAIT;
               end
            end
            ST_XWAIT: begin
               if (cnt == XD_LAST) begin
                  cnt <= '0;
                  if (fc_q == '0) begin
                     state <= ST_FIN;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     xmit  <= XMIT_IDLE;
                  end else begin
                     state <= ST_PRE;
                     TX_EN <= 1'b1;
                     TXD   <= PREAMBLE_BYTE;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_PRE: begin
               if (cnt == PRE_LAST) begin
                  cnt   <= '0;
                  state <= ST_SFD;
                  TXD   <= SFD_BYTE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_SFD: begin
               cnt <= '0;
               if (len_q == '0) begin
                  state       <= ST_IPG;
                  TX_EN       <= 1'b0;
                  TXD         <= 8'h00;
                  frames_sent <= sent_inc;
               end else begin
                  state <= ST_PAY;
                  TXD   <= pat_byte;
                  TX_ER <= err_q && (eidx_q == '0);
               end
            end
            ST_PAY: begin
               if (cnt == len_q - 1'b1) begin
                  cnt         <= '0;
                  state       <= ST_IPG;
                  TX_EN       <= 1'b0;
                  TX_ER       <= 1'b0;
                  TXD         <= 8'h00;
                  frames_sent <= sent_inc;
               end else begin
                  cnt   <= cnt + 1'b1;
                  TXD   <= pat_byte;
                  TX_ER <= err_q && (eidx_q == cnt + 1'b1);
               end
            end
            ST_IPG: begin
               if (cnt == IPG_LAST) begin
                  cnt <= '0;
                  if (frames_sent < fc_q) begin
                     state <= ST_PRE;
                     TX_EN <= 1'b1;
                     TXD   <= PREAMBLE_BYTE;
                  end else begin
                     state <= ST_FIN;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     xmit  <= XMIT_IDLE;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_FIN: begin
               done  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gmii_frame_gen.sv
// tb/tb_gmii_frame_gen.sv - scoreboard bench for gmii_frame_gen with randomized runs
module tb_gmii_frame_gen;

   localparam int PRE_N = 7;
   localparam int IPG_N = 12;
   localparam int XD_N  = 5;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  mode = 2'b00;
   logic [7:0]  seed = 8'h00;
   logic [10:0] payload_len = '0;
   logic [7:0]  frame_count = '0;
   logic        err_en = 1'b0;
   logic [10:0] err_index = '0;
   logic [7:0]  TXD;
   logic        TX_EN;
   logic        TX_ER;
   logic [2:0]  xmit;
   logic        busy;
   logic        done;
   logic [7:0]  frames_sent;

   int checks = 0;
   int passed = 0;

   logic [8:0] q_byte[$];
   int         q_flen[$];
   int         q_fnum[$];
   int         q_done[$];
   logic [8:0] e_b;

   bit mon_en = 1'b0;
   bit first  = 1'b1;
   int idle   = 0;
   int burst  = 0;

   always #4 clk = ~clk;

   gmii_frame_gen dut (
      .GTX_CLK       (clk),
      .mr_main_reset (rst),
      .start         (start),
      .mode          (mode),
      .seed          (seed),
      .payload_len   (payload_len),
      .frame_count   (frame_count),
      .err_en        (err_en),
      .err_index     (err_index),
      .TXD           (TXD),
      .TX_EN         (TX_EN),
      .TX_ER         (TX_ER),
      .xmit          (xmit),
      .busy          (busy),
      .done          (done),
      .frames_sent   (frames_sent)
   );

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
   endtask

   // Monitor: pops the scoreboard whenever the DUT drives a byte, ends a burst, or pulses done
   always @(negedge clk) begin
      if (mon_en && !rst) begin
         if (TX_EN) begin
            if (burst == 0) begin
               check("gap_before_frame", idle, first ? XD_N : IPG_N);
               first = 1'b0;
            end
            burst++;
            if (q_byte.size() == 0) begin
               check("unexpected_byte", 1, 0);
            end else begin
               e_b = q_byte.pop_front();
               check("txd", int'(TXD), int'(e_b[7:0]));
               check("tx_er", int'(TX_ER), int'(e_b[8]));
            end
         end else begin
            if (burst != 0) begin
               if (q_flen.size() == 0) begin
                  check("unexpected_frame", 1, 0);
               end else begin
                  check("frame_len", burst, q_flen.pop_front());
                  check("frames_sent_step", int'(frames_sent), q_fnum.pop_front());
               end
               burst = 0;
               idle  = 0;
            end
            check("idle_quiet", int'({TX_ER, TXD}), 0);
            if (busy) idle++;
         end
         if (done) begin
            if (q_done.size() == 0) begin
               check("unexpected_done", 1, 0);
            end else begin
               check("done_frames_sent", int'(frames_sent), q_done.pop_front());
               check("done_gap", idle, first ? XD_N : IPG_N);
               check("done_xmit", int'(xmit), 1);
               check("done_busy", int'(busy), 0);
            end
         end
      end
   end

   // Reference model: expand one run into the byte stream, frame lengths and done record
   task automatic issue(input logic [1:0] m, input logic [7:0] s, input int len, input int fc,
                        input bit ee, input int ei, input bit poke);
      logic [7:0] d;
      logic [7:0] b;
      for (int f = 1; f <= fc; f++) begin
         for (int i = 0; i < PRE_N; i++) q_byte.push_back({1'b0, 8'h55});
         q_byte.push_back({1'b0, 8'hD5});
         d = (m == 2'd2 && s == 8'h00) ? 8'h01 : s;
         for (int i = 0; i < len; i++) begin
            if (m == 2'd1)      b = 8'((int'(s) + i) % 256);
            else if (m == 2'd2) b = d;
            else                b = s;
            q_byte.push_back({1'(ee && i == ei), b});
            d = 8'((d << 1) | 8'(^(d & 8'hB8)));
         end
         q_flen.push_back(PRE_N + 1 + len);
         q_fnum.push_back(f > 255 ? 255 : f);
      end
      q_done.push_back(fc > 255 ? 255 : fc);
      @(posedge clk); #1;
      first = 1'b1; idle = 0; burst = 0;
      mode = m; seed = s; payload_len = len[10:0]; frame_count = fc[7:0];
      err_en = ee; err_index = ei[10:0]; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("start_xmit", int'(xmit), 2);
      check("start_busy", int'(busy), 1);
      mode = 2'($urandom); seed = 8'($urandom); payload_len = 11'($urandom_range(0, 30));
      frame_count = 8'($urandom_range(0, 5)); err_en = 1'($urandom); err_index = 11'($urandom_range(0, 10));
      if (poke) begin
         repeat (3) @(posedge clk);
         #1 start = 1'b1;
         @(posedge clk);
         #1 start = 1'b0;
      end
   endtask

   task automatic finish_run();
      for (int c = 0; c < 4000 && q_done.size() != 0; c++) @(posedge clk);
      #1;
      check("run_done_seen", q_done.size(), 0);
      check("bytes_left", q_byte.size(), 0);
      check("frames_left", q_flen.size(), 0);
      q_byte.delete(); q_flen.delete(); q_fnum.delete(); q_done.delete();
      repeat (2) @(posedge clk);
   endtask

   task automatic run(input logic [1:0] m, input logic [7:0] s, input int len, input int fc,
                      input bit ee, input int ei, input bit poke);
      issue(m, s, len, fc, ee, ei, poke);
      finish_run();
   endtask

   initial begin
      int rl;
      int rfc;
      repeat (3) @(posedge clk);
      #1;
      check("rst_txd", int'(TXD), 0);
      check("rst_tx_en", int'(TX_EN), 0);
      check("rst_tx_er", int'(TX_ER), 0);
      check("rst_xmit", int'(xmit), 1);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_frames_sent", int'(frames_sent), 0);
      rst = 1'b0;
      mon_en = 1'b1;
      repeat (2) @(posedge clk);

      run(2'd1, 8'h01, 10, 1, 1'b0, 0, 1'b0);
      run(2'd2, 8'h01, 7, 1, 1'b0, 0, 1'b0);
      run(2'd0, 8'hAA, 4, 3, 1'b0, 0, 1'b1);
      run(2'd1, 8'h5A, 6, 1, 1'b1, 3, 1'b0);
      run(2'd1, 8'h5A, 6, 1, 1'b1, 6, 1'b0);

      issue(2'd1, 8'h10, 20, 3, 1'b0, 0, 1'b0);
      for (int c = 0; c < 2000 && !(frames_sent == 8'd1 && TX_EN && burst > 12); c++) @(posedge clk);
      check("reach_frame2_payload", int'(frames_sent == 8'd1 && TX_EN && burst > 12), 1);
      #1;
      mon_en = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_tx_en", int'(TX_EN), 0);
      check("abort_txd", int'(TXD), 0);
      check("abort_xmit", int'(xmit), 1);
      check("abort_busy", int'(busy), 0);
      check("abort_frames_sent", int'(frames_sent), 0);
      q_byte.delete(); q_flen.delete(); q_fnum.delete(); q_done.delete();
      burst = 0; idle = 0;
      mon_en = 1'b1;
      repeat (2) @(posedge clk);

      run(2'd3, 8'h33, 5, 2, 1'b0, 0, 1'b0);
      run(2'd1, 8'h77, 9, 0, 1'b1, 0, 1'b0);
      run(2'd2, 8'h3C, 0, 2, 1'b1, 0, 1'b0);
      run(2'd2, 8'h00, 5, 1, 1'b1, 0, 1'b0);
      run(2'd1, 8'hFC, 8, 1, 1'b1, 7, 1'b0);

      for (int r = 0; r < 8; r++) begin
         rl  = $urandom_range(0, 24);
         rfc = $urandom_range(1, 3);
         run(2'($urandom), 8'($urandom), rl, rfc, 1'($urandom), $urandom_range(0, rl + 1), 1'($urandom));
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
